// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing the frame-buffer write port between drawers.
// Write strobe is registered 1 cycle after the transfer; a requester stalls via req_ready until granted.
module fb_write_arbiter #(
  parameter int N_REQ             = 3,
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int PIXELS_COUNT     = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  localparam int ADDR_WIDTH       = $clog2(PIXELS_COUNT),
  localparam int ID_WIDTH         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ-1:0]            req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        hold,
  output logic                        fb_write_enable,
  output logic [ADDR_WIDTH-1:0]       fb_write_addr,
  output logic                        fb_write_data,
  output logic [ID_WIDTH-1:0]         grant_id,
  output logic                        idle,
  output logic                        addr_error
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_data_q, wr_data_d;
  logic                  addr_err_q, addr_err_d;

  logic [ID_WIDTH-1:0]   sel_id;
  logic                  sel_found;
  int                    idx;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  xfer;
  logic                  in_range;

  // Explicit wrap so non-power-of-two N_REQ never points at a missing requester.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
    if (int'(v) >= N_REQ - 1) return '0;
    return v + 1'b1;
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(idx);
      end
    end
  end

  assign gnt_addr = req_addr[int'(grant_id_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign xfer     = (state_q == BURST) && req_valid[grant_id_q];
  assign in_range = {1'b0, gnt_addr} < (ADDR_WIDTH+1)'(PIXELS_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    addr_err_d = addr_err_q;
    case (state_q)
      IDLE: begin
        if (!hold && sel_found) begin
          grant_id_d = sel_id;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          // Out-of-range pixels are still consumed so the drawer never deadlocks.
          if (in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = gnt_addr;
            wr_data_d = req_data[grant_id_q];
          end else begin
            addr_err_d = 1'b1;
          end
          if (req_last[grant_id_q]) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(grant_id_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == BURST) req_ready[grant_id_q] = 1'b1;
  end

  assign fb_write_enable = wr_en_q;
  assign fb_write_addr   = wr_addr_q;
  assign fb_write_data   = wr_data_q;
  assign grant_id        = grant_id_q;
  assign addr_error      = addr_err_q;
  assign idle            = (state_q == IDLE) && !wr_en_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed stimulus for fb_write_arbiter; expected writes queued at issue time, checked by a monitor.
module tb_fb_write_arbiter;
  localparam int N   = 3;
  localparam int AW  = 19;
  localparam int PIX = 640 * 480;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_data, req_last, req_ready;
  logic [N*AW-1:0] req_addr;
  logic          hold;
  logic          fb_write_enable;
  logic [AW-1:0] fb_write_addr;
  logic          fb_write_data;
  logic [1:0]    grant_id;
  logic          idle, addr_error;

  typedef struct { int addr; bit data; bit last; int gap; } pix_t;
  typedef struct { int addr; bit data; int gid; int dead; } exp_t;

  pix_t   pix_q[N][$];
  exp_t   exp_q[$];
  int     gap_left[N];
  int     hs_cnt[N];
  bit     strobe_due;
  logic [N-1:0] hs;
  int     checks = 0;
  int     errors = 0;

  fb_write_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready), .hold(hold),
    .fb_write_enable(fb_write_enable), .fb_write_addr(fb_write_addr),
    .fb_write_data(fb_write_data), .grant_id(grant_id), .idle(idle),
    .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pix(input int i, input int addr, input bit data, input bit last, input int gap);
    pix_t p;
    p.addr = addr; p.data = data; p.last = last; p.gap = gap;
    pix_q[i].push_back(p);
  endtask

  task automatic push_exp(input int addr, input bit data, input int gid, input int dead);
    exp_t e;
    e.addr = addr; e.data = data; e.gid = gid; e.dead = dead;
    exp_q.push_back(e);
  endtask

  task automatic wait_hs(input int i, input int target, input string name);
    int n;
    n = 0;
    while (hs_cnt[i] < target && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (hs_cnt[i] < target) begin
      errors++;
      $display("FAIL %s: requester %0d made %0d handshakes, needed %0d", name, i, hs_cnt[i], target);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      busy = (exp_q.size() != 0) || !idle;
      for (int i = 0; i < N; i++) if (pix_q[i].size() != 0) busy = 1'b1;
    end while (busy && n < 300);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: not drained, %0d writes outstanding, idle %0d", name, exp_q.size(), idle);
    end
  endtask

  // Requester agents: handshake sampled at negedge, takes effect at the next posedge.
  initial begin
    req_valid = '0; req_addr = '0; req_data = '0; req_last = '0;
    strobe_due = 1'b0; hs = '0;
    for (int i = 0; i < N; i++) begin gap_left[i] = 0; hs_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      strobe_due = 1'b0;
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (hs[i] && pix_q[i].size() > 0) begin
            if (pix_q[i][0].addr < PIX) strobe_due = 1'b1;
            void'(pix_q[i].pop_front());
            hs_cnt[i]++;
            gap_left[i] = (pix_q[i].size() > 0) ? pix_q[i][0].gap : 0;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (pix_q[i].size() == 0) begin
          req_valid[i] = 1'b0;
        end else if (gap_left[i] > 0) begin
          req_valid[i] = 1'b0;
          gap_left[i]--;
        end else begin
          req_valid[i]           = 1'b1;
          req_addr[i*AW +: AW]   = AW'(pix_q[i][0].addr);
          req_data[i]            = pix_q[i][0].data;
          req_last[i]            = pix_q[i][0].last;
        end
      end
    end
  end

  // Monitor: strobe timing plus scoreboard of write address/data/grant and dead-cycle gaps.
  initial begin
    int   since;
    exp_t e;
    since = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("strobe_timing", fb_write_enable, strobe_due);
        if (fb_write_enable) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0d written, no write expected", fb_write_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", fb_write_addr, e.addr);
            check("wr_data", fb_write_data, e.data);
            check("wr_gid", grant_id, e.gid);
            if (e.dead >= 0) check("dead_cycles", since, e.dead);
          end
          since = 0;
        end else begin
          since++;
        end
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; hold = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", fb_write_enable, 0);
    check("rst_addr", fb_write_addr, 0);
    check("rst_data", fb_write_data, 0);
    check("rst_ready", req_ready, 0);
    check("rst_gid", grant_id, 0);
    check("rst_idle", idle, 1);
    check("rst_err", addr_error, 0);
    @(negedge clk); #1 rst = 1'b0;

    // Reset mid-burst
    for (int k = 0; k < 4; k++) push_pix(1, 100 + k, k[0], k == 3, 0);
    push_exp(100, 0, 1, -1);
    push_exp(101, 1, 1, 0);
    wait_hs(1, 2, "midburst_hs");
    @(negedge clk); #1 rst = 1'b1;
    #1;
    check("arst_we", fb_write_enable, 0);
    check("arst_addr", fb_write_addr, 0);
    check("arst_ready", req_ready, 0);
    check("arst_gid", grant_id, 0);
    check("arst_idle", idle, 1);
    for (int i = 0; i < N; i++) begin pix_q[i].delete(); gap_left[i] = 0; end
    exp_q.delete();
    @(negedge clk); #1 rst = 1'b0;
    push_pix(2, 200, 1, 0, 0);
    push_pix(2, 201, 0, 1, 0);
    push_exp(200, 1, 2, -1);
    push_exp(201, 0, 2, 0);
    wait_done("post_reset");
    check("post_reset_gid", grant_id, 2);

    // Round-robin 0,1,2,0 with one dead cycle between bursts
    push_pix(0, 300, 1, 0, 0); push_pix(0, 301, 0, 1, 0);
    push_pix(0, 306, 1, 0, 0); push_pix(0, 307, 1, 1, 0);
    push_pix(1, 302, 0, 0, 0); push_pix(1, 303, 1, 1, 0);
    push_pix(2, 304, 1, 0, 0); push_pix(2, 305, 0, 1, 0);
    push_exp(300, 1, 0, -1); push_exp(301, 0, 0, 0);
    push_exp(302, 0, 1, 1);  push_exp(303, 1, 1, 0);
    push_exp(304, 1, 2, 1);  push_exp(305, 0, 2, 0);
    push_exp(306, 1, 0, 1);  push_exp(307, 1, 0, 0);
    wait_done("round_robin");

    // Burst lock across a 3-cycle bubble
    base = hs_cnt[0];
    push_pix(0, 400, 1, 0, 0); push_pix(0, 401, 0, 0, 3); push_pix(0, 402, 1, 1, 0);
    push_exp(400, 1, 0, -1); push_exp(401, 0, 0, 3); push_exp(402, 1, 0, 0);
    wait_hs(0, base + 1, "bubble_start");
    push_pix(1, 410, 1, 1, 0);
    push_pix(2, 420, 0, 1, 0);
    push_exp(410, 1, 1, 1); push_exp(420, 0, 2, 1);
    @(negedge clk); #1;
    check("bubble_ready", req_ready, 3'b001);
    check("bubble_gid", grant_id, 0);
    wait_done("bubble");
    check("err_before_oor", addr_error, 0);

    // Out-of-range address
    base = hs_cnt[2];
    push_pix(2, PIX, 1, 0, 0);
    push_pix(2, PIX - 1, 1, 1, 0);
    push_exp(PIX - 1, 1, 2, -1);
    wait_hs(2, base + 1, "oor_hs");
    check("oor_no_we", fb_write_enable, 0);
    check("oor_addr_hold", fb_write_addr, 420);
    check("oor_err_set", addr_error, 1);
    wait_done("oor");
    check("oor_last_addr", fb_write_addr, PIX - 1);

    // Hold gating
    base = hs_cnt[1];
    for (int k = 0; k < 4; k++) push_pix(1, 500 + k, k[0], k == 3, 0);
    push_exp(500, 0, 1, -1); push_exp(501, 1, 1, 0);
    push_exp(502, 0, 1, 0);  push_exp(503, 1, 1, 0);
    wait_hs(1, base + 1, "hold_burst_start");
    hold = 1'b1;
    push_pix(0, 510, 0, 1, 0);
    push_exp(510, 0, 0, -1);
    wait_hs(1, base + 4, "hold_burst_end");
    @(negedge clk); #1;
    check("hold_last_we", fb_write_enable, 1);
    check("hold_last_idle", idle, 0);
    @(negedge clk); #1;
    check("hold_idle", idle, 1);
    repeat (4) @(negedge clk);
    #1;
    check("hold_no_grant", req_ready, 0);
    check("hold_gid", grant_id, 1);
    check("hold_idle_still", idle, 1);
    @(posedge clk); #2 hold = 1'b0;
    @(negedge clk); #1;
    check("release_before_edge", req_ready, 0);
    @(negedge clk); #1;
    check("release_ready", req_ready, 3'b001);
    check("release_gid", grant_id, 0);
    wait_done("hold");

    // Last pixel with immediate re-request: rotation goes to 1 first
    base = hs_cnt[0];
    push_pix(0, 600, 1, 0, 0); push_pix(0, 601, 0, 1, 0); push_pix(0, 602, 1, 1, 0);
    push_exp(600, 1, 0, -1); push_exp(601, 0, 0, 0);
    wait_hs(0, base + 1, "rereq_start");
    push_pix(1, 610, 1, 1, 0);
    push_exp(610, 1, 1, 1); push_exp(602, 1, 0, 1);
    wait_done("rereq");
    check("err_sticky", addr_error, 1);
    check("final_gid", grant_id, 0);
    check("final_addr", fb_write_addr, 602);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single frame-buffer write port between the pixel-producing drawers (fill, line, symbol), replacing the ad-hoc OR of their write buses.
- Round-robin arbitration with burst locking: a grant is held until the requester flags its last pixel.
- Registered write output with an out-of-range address check.
- Provides `hold`/`idle` so the sequencing logic can quiesce all drawing before a buffer swap.

Parameters:
- N_REQ, 3, number of requesters; legal range 1..8.
- HOR_ACTIVE_PIXELS, 640, frame width in pixels.
- VER_ACTIVE_PIXELS, 480, frame height in pixels.
- PIXELS_COUNT, HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS (localparam), number of addressable pixels.
- ADDR_WIDTH, $clog2(PIXELS_COUNT) (localparam, 19 at defaults), address width.
- ID_WIDTH, max(1,$clog2(N_REQ)) (localparam), grant index width.

Ports:
- clk  in  1  system pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*ADDR_WIDTH  per-requester pixel address; slice i is [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  N_REQ  per-requester pixel value.
- req_last  in  N_REQ  marks the final pixel of the requester's burst.
- req_ready  out  N_REQ  per-requester accept.
- hold  in  1  block new grants; used before a buffer swap.
- fb_write_enable  out  1  frame-buffer write strobe.
- fb_write_addr  out  ADDR_WIDTH  frame-buffer write address.
- fb_write_data  out  1  frame-buffer write data.
- grant_id  out  ID_WIDTH  index of the current or last granted requester.
- idle  out  1  no burst active and no write in flight.
- addr_error  out  1  sticky; set on an accepted out-of-range address.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - req_ready=0, fb_write_enable=0, fb_write_addr=0, fb_write_data=0, addr_error=0.
  - Any in-flight write is dropped.
- States:
  - IDLE: no grant. If hold=0 and |req_valid, select the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod N_REQ. Register grant_id=i; next state BURST. If hold=1, or no valid request, stay IDLE.
  - BURST: req_ready[grant_id]=1; all other ready bits 0. req_ready is a function of registered state only, never of req_valid.
    - Transfer when req_valid[g] && req_ready[g].
    - Transfer with req_last[g]=1: next state IDLE, rr_ptr=(g+1) mod N_REQ.
    - req_valid[g]=0 mid-burst: grant stays, no write (bubble), no timeout.
- Write output (registered; latency exactly 1 cycle from the transfer edge):
  - In-range address (req_addr < PIXELS_COUNT): fb_write_enable=1, fb_write_addr=req_addr slice, fb_write_data=req_data[g].
  - Otherwise fb_write_enable=0; fb_write_addr/fb_write_data hold their previous values.
  - Out-of-range address: transfer is still accepted (ready is not withdrawn), the write is suppressed, and addr_error goes high and stays high until rst.
- Arbitration cost: one IDLE cycle between consecutive bursts. Back-to-back bursts therefore need ≥1 dead cycle; maximum throughput within a burst is 1 pixel/cycle.
- hold:
  - Sampled only in IDLE; never aborts a burst in progress.
  - Asserting hold in the same cycle as req_valid in IDLE: no grant.
- idle = (state==IDLE) && !fb_write_enable, combinational from registers. Asserted from the cycle after the last write strobe of the final burst.
- Requester behaviour that is not checked:
  - req_addr/req_data/req_last of non-granted requesters are ignored.
  - req_valid without req_ready may be held indefinitely.
  - Requesters must keep valid asserted until accepted.
- N_REQ=1: rr_ptr stays 0; behaviour is otherwise identical.
- Width rules:
  - Address comparison is unsigned, full ADDR_WIDTH.
  - rr_ptr wraps from N_REQ-1 to 0 (non-power-of-two N_REQ must wrap explicitly, not by overflow).

Test Plan:
- Reset mid-burst: requester 1 granted, 2 pixels accepted, rst pulse → on the same edge all outputs are 0 and idle=1. First post-reset request from requester 2 is granted (rr_ptr=0, so 0 and 1 are searched first, both idle).
- Round-robin: all three valid continuously, each burst 2 pixels → grant_id sequence 0,1,2,0. Each burst is separated by exactly one fb_write_enable=0 cycle. Addresses appear one cycle after each transfer.
- Burst lock with bubble: requester 0 drops valid for 3 cycles mid-burst while 1 and 2 are valid → grant stays 0, no writes for 3 cycles, then 0 resumes; requester 1 is granted after 0's last pixel.
- Out-of-range: requester 2 sends addr 307200 then 307199 (last) → first is accepted with no strobe and addr_error=1. Second writes addr 307199. addr_error remains 1 through later bursts.
- Hold gating: hold=1 while requester 1 is in a 4-pixel burst → all 4 writes complete, idle=1 one cycle after the last strobe. Pending requester 0 is not granted until hold=0, and is then granted on the next edge.
- Simultaneous last and new request: requester 0 last pixel while requester 0 also immediately re-requests and 1 is valid → next grant is 1 (rr_ptr=1), then 0.
